// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start(1), DATA_W bits LSB-first, optional even parity (SERIAL_TX_PARITY_EN), stop(0).
// Latency: first line bit (START) one cycle after accept; frame is DATA_W+2 cycles (+1 with parity).
// Backpressure: ready only in IDLE/STOP; valid while not ready is ignored, upstream holds the word.
module serial_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              __in0,
    input  logic [DATA_W-1:0] __in1,
    output logic              __out0,
    output logic              __out1
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, stateNext;
    logic [DATA_W-1:0]   shiftReg, shiftNext;
    logic [CNT_W-1:0]    bitCnt, cntNext;
    logic                lineReg, lineNext;
    logic                accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                parityAcc, parNext;
`endif

    assign __out1 = (state == IDLE) || (state == STOP);
    assign __out0 = lineReg;
    // Ready is a pure state decode; reset priority in the flop block suppresses accepts.
    assign accept = __in0 && __out1;

    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        cntNext   = bitCnt;
        lineNext  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parNext   = parityAcc;
`endif
        case (state)
            IDLE:  stateNext = IDLE;
            START: stateNext = DATA;
            DATA: begin
                shiftNext = shiftReg >> 1;
                cntNext   = bitCnt + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                parNext   = parityAcc ^ shiftReg[0];
                if (bitCnt == LAST_BIT) stateNext = PARITY;
`else
                if (bitCnt == LAST_BIT) stateNext = STOP;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: stateNext = STOP;
`endif
            STOP:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (accept) begin
            stateNext = START;
            shiftNext = __in1;
            cntNext   = '0;
`ifdef SERIAL_TX_PARITY_EN
            parNext   = 1'b0;
`endif
        end

        // Line level is computed from the next state so the output is a plain flop.
        case (stateNext)
            START:   lineNext = 1'b1;
            DATA:    lineNext = shiftNext[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  lineNext = parNext;
`endif
            default: lineNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitCnt    <= '0;
            lineReg   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parityAcc <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftNext;
            bitCnt    <= cntNext;
            lineReg   <= lineNext;
`ifdef SERIAL_TX_PARITY_EN
            parityAcc <= parNext;
`endif
        end
    end

endmodule
